// File: rtl/mux_rr_nto1.sv
// N:1 registered multiplexer with valid/ready on every port; fixed-selector or round-robin grant.
// Optional registered even parity of data_out when MUX_PARITY_EN is defined.
module mux_rr_nto1 #(
    parameter int W = 2,
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   reset_L,
    input  logic                   mode_rr,
    input  logic [$clog2(N)-1:0]   selector,
    input  logic [N-1:0]           valid_in,
    input  logic [N*W-1:0]         data_in,
    output logic [N-1:0]           ready_in,
    output logic                   valid_out,
    output logic [W-1:0]           data_out,
    output logic [$clog2(N)-1:0]   chan_out,
    input  logic                   ready_out
`ifdef MUX_PARITY_EN
    ,
    output logic                   parity_out
`endif
);

    localparam int SELW = $clog2(N);

    logic            r_valid;
    logic [W-1:0]    r_data;
    logic [SELW-1:0] r_chan;
    logic [SELW-1:0] r_last_grant;

    logic [W-1:0]    w_chan_data [N];
    logic            w_rr_found;
    logic [SELW-1:0] w_rr_idx;
    logic            w_sel_ok;
    logic            w_cand_found;
    logic [SELW-1:0] w_grant;
    logic            w_may_load;
    logic            w_load;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            assign w_chan_data[gi] = data_in[gi*W +: W];
            assign ready_in[gi]    = w_load && (w_grant == SELW'(gi));
        end
    endgenerate

    // Scan from the farthest offset down so the nearest requester after last_grant wins.
    always_comb begin
        int idx;
        idx        = 0;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(r_last_grant) + k) % N;
            if (valid_in[idx]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = SELW'(idx);
            end
        end
    end

    assign w_sel_ok     = (int'(selector) < N) && valid_in[selector];
    assign w_cand_found = mode_rr ? w_rr_found : w_sel_ok;
    assign w_grant      = mode_rr ? w_rr_idx : selector;
    assign w_may_load   = !r_valid || ready_out;
    // Gating with reset_L keeps ready_in quiet while reset is held.
    assign w_load       = reset_L && w_may_load && w_cand_found;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_chan       <= '0;
            r_last_grant <= SELW'(N - 1);
        end else if (w_load) begin
            r_valid      <= 1'b1;
            r_data       <= w_chan_data[w_grant];
            r_chan       <= w_grant;
            r_last_grant <= w_grant;
        end else if (ready_out) begin
            r_valid      <= 1'b0;
        end
    end

`ifdef MUX_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^w_chan_data[w_grant];
        end
    end

    assign parity_out = r_parity;
`endif

    assign valid_out = r_valid;
    assign data_out  = r_data;
    assign chan_out  = r_chan;

endmodule

// File: tb/tb_mux_rr_nto1.sv
// Self-checking bench for mux_rr_nto1 (N=4, W=2): directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_mux_rr_nto1;

    localparam int W    = 2;
    localparam int N    = 4;
    localparam int SELW = 2;

    logic            clk = 1'b0;
    logic            reset_L;
    logic            mode_rr;
    logic [SELW-1:0] selector;
    logic [N-1:0]    valid_in;
    logic [N*W-1:0]  data_in;
    logic [N-1:0]    ready_in;
    logic            valid_out;
    logic [W-1:0]    data_out;
    logic [SELW-1:0] chan_out;
    logic            ready_out;
`ifdef MUX_PARITY_EN
    logic            parity_out;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_chan;
    int           m_last;

    mux_rr_nto1 #(.W(W), .N(N)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .mode_rr   (mode_rr),
        .selector  (selector),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .chan_out  (chan_out),
        .ready_out (ready_out)
`ifdef MUX_PARITY_EN
        ,
        .parity_out(parity_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int pick_channel();
        if (!mode_rr) begin
            if (int'(selector) < N && valid_in[selector]) return int'(selector);
            return -1;
        end
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (valid_in[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_chan  = 0;
        m_last  = N - 1;
    endtask

    task automatic check_outputs();
        check_eq("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
        check_eq("data_out", {30'd0, data_out}, {30'd0, m_data});
        check_eq("chan_out", {30'd0, chan_out}, m_chan);
`ifdef MUX_PARITY_EN
        check_eq("parity_out", {31'd0, parity_out}, {31'd0, ^m_data});
`endif
    endtask

    // Called one time unit after a rising edge with inputs already driven.
    task automatic cycle(output int granted);
        int           c;
        logic         load;
        logic [N-1:0] exp_rdy;
        #1;
        c       = pick_channel();
        load    = (!m_valid || ready_out) && (c >= 0);
        exp_rdy = load ? N'(1 << c) : '0;
        check_eq("ready_in", {28'd0, ready_in}, {28'd0, exp_rdy});
        granted = load ? c : -1;
        @(posedge clk);
        if (load) begin
            m_data  = data_in[c*W +: W];
            m_chan  = c;
            m_valid = 1'b1;
            m_last  = c;
        end else if (ready_out) begin
            m_valid = 1'b0;
        end
        #1;
        $display("cycle mode=%0d sel=%0d vin=%b rdy_out=%0d grant=%0d -> vout=%0d dout=%0h chan=%0d",
                 mode_rr, selector, valid_in, ready_out, granted, valid_out, data_out, chan_out);
        check_outputs();
    endtask

    task automatic do_reset();
        reset_L  = 1'b0;
        valid_in = '1;
        #1;
        model_reset();
        check_eq("rst_valid", {31'd0, valid_out}, 32'd0);
        check_eq("rst_data", {30'd0, data_out}, 32'd0);
        check_eq("rst_ready", {28'd0, ready_in}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid2", {31'd0, valid_out}, 32'd0);
        check_eq("rst_ready2", {28'd0, ready_in}, 32'd0);
        reset_L = 1'b1;
    endtask

    initial begin
        int g;
        int rr_exp [6];
        rr_exp = '{0, 1, 3, 0, 1, 3};

        reset_L   = 1'b0;
        mode_rr   = 1'b0;
        selector  = '0;
        valid_in  = '1;
        data_in   = '0;
        ready_out = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // fixed selector on channel 2
        mode_rr   = 1'b0;
        selector  = 2'd2;
        valid_in  = 4'b1111;
        ready_out = 1'b1;
        for (int n = 0; n < 4; n++) begin
            data_in = {2'($urandom), 2'b11, 2'($urandom), 2'($urandom)};
            cycle(g);
            check_eq("fix_chan", {30'd0, chan_out}, 32'd2);
            check_eq("fix_data", {30'd0, data_out}, 32'd3);
        end

        // round-robin over 1011 from a fresh reset
        @(posedge clk);
        #1;
        do_reset();
        mode_rr   = 1'b1;
        valid_in  = 4'b1011;
        ready_out = 1'b1;
        for (int n = 0; n < 6; n++) begin
            data_in = 8'($urandom);
            cycle(g);
            check_eq("rr_seq", {30'd0, chan_out}, rr_exp[n]);
        end

        // backpressure: held word stays, then round-robin order resumes
        ready_out = 1'b0;
        for (int n = 0; n < 3; n++) begin
            data_in = 8'($urandom);
            cycle(g);
            check_eq("bp_chan", {30'd0, chan_out}, 32'd3);
        end
        ready_out = 1'b1;
        cycle(g);
        check_eq("bp_resume", {30'd0, chan_out}, 32'd0);

        // drain without refill
        valid_in = 4'b0000;
        cycle(g);
        check_eq("drain_valid", {31'd0, valid_out}, 32'd0);

        // load a word, then assert reset in the middle of the cycle
        valid_in = 4'b0100;
        cycle(g);
        #3;
        reset_L = 1'b0;
        #1;
        model_reset();
        check_eq("midrst_valid", {31'd0, valid_out}, 32'd0);
        check_eq("midrst_data", {30'd0, data_out}, 32'd0);
        @(posedge clk);
        #1;
        reset_L = 1'b1;

`ifdef MUX_PARITY_EN
        mode_rr  = 1'b0;
        selector = 2'd1;
        valid_in = 4'b0010;
        data_in  = 8'b00_00_01_00;
        cycle(g);
        check_eq("par_01", {31'd0, parity_out}, 32'd1);
        data_in  = 8'b00_00_11_00;
        cycle(g);
        check_eq("par_11", {31'd0, parity_out}, 32'd0);
`endif

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            if (($urandom % 8) == 0) mode_rr = ~mode_rr;
            selector  = 2'($urandom);
            valid_in  = 4'($urandom);
            data_in   = 8'($urandom);
            ready_out = ($urandom % 4) != 0;
            cycle(g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
